// File: rtl/multiplier_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multiplier_arbiter_pkg : state encoding and defaults for the arbiter |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
package multiplier_arbiter_pkg;

   localparam int NUM_REQ_DEFAULT = 4;
   localparam int WIDTH_DEFAULT   = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Index width for a requester pointer; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/multiplier_arbiter_rr_priority_picker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_priority_picker : combinational round-robin pick after 'last'     |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module rr_priority_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   logic [NUM_REQ-1:0] masked;

   always_comb begin
      masked    = '0;
      grant_idx = '0;
      grant_any = |req;
      for (int i = 0; i < NUM_REQ; i++) begin
         masked[i] = req[i] & (i > int'(last));
      end
      // Lowest requester above the pointer wins; otherwise wrap to lowest overall.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) grant_idx = IDX_W'(i);
      end
      if (|masked) begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (masked[i]) grant_idx = IDX_W'(i);
         end
      end
      grant = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
   end

endmodule
`default_nettype wire

// File: rtl/multiplier_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multiplier_arbiter : shares one external multiplier among requesters |
// | Revision 1.0                                                         |
// +--------------------------------------------------------------------+
module multiplier_arbiter
   import multiplier_arbiter_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEFAULT,
   parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_multiplier,
   input  logic [NUM_REQ*WIDTH-1:0] req_multiplicand,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       resp_valid,
   output logic [2*WIDTH-1:0]       resp_product,
   output logic                     mult_start,
   output logic [WIDTH-1:0]         mult_multiplier,
   output logic [WIDTH-1:0]         mult_multiplicand,
   input  logic [2*WIDTH-1:0]       mult_product,
   input  logic                     mult_done,
   output logic                     busy
);

   localparam int IDX_W = idx_width(NUM_REQ);

   state_t               state;
   state_t               state_next;
   logic [IDX_W-1:0]     last_grant;
   logic [IDX_W-1:0]     cur_idx;
   logic                 wait_armed;
   logic                 grant_fire;
   logic [2*WIDTH-1:0]   result;
   logic [NUM_REQ-1:0]   pick_grant;
   logic [IDX_W-1:0]     pick_idx;
   logic                 pick_any;
   logic [WIDTH-1:0]     sel_multiplier;
   logic [WIDTH-1:0]     sel_multiplicand;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req       (req_valid),
      .last      (last_grant),
      .grant     (pick_grant),
      .grant_idx (pick_idx),
      .grant_any (pick_any)
   );

   always_comb begin
      sel_multiplier   = '0;
      sel_multiplicand = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_idx == IDX_W'(i)) begin
            sel_multiplier   = req_multiplier[i*WIDTH +: WIDTH];
            sel_multiplicand = req_multiplicand[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      req_ready  = '0;
      resp_valid = '0;
      mult_start = 1'b0;
      grant_fire = 1'b0;
      case (state)
         IDLE: begin
            if (pick_any) begin
               req_ready  = pick_grant;
               grant_fire = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            mult_start = 1'b1;
            state_next = WAIT;
         end
         WAIT: begin
            // First WAIT cycle may still see the previous operation's done.
            if (wait_armed && mult_done) state_next = RESP;
         end
         RESP: begin
            resp_valid = NUM_REQ'(1) << cur_idx;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant        <= IDX_W'(NUM_REQ - 1);
         cur_idx           <= '0;
         wait_armed        <= 1'b0;
         mult_multiplier   <= '0;
         mult_multiplicand <= '0;
         result            <= '0;
      end else begin
         wait_armed <= (state == WAIT);
         if (grant_fire) begin
            last_grant        <= pick_idx;
            cur_idx           <= pick_idx;
            mult_multiplier   <= sel_multiplier;
            mult_multiplicand <= sel_multiplicand;
         end
         if (state == WAIT && wait_armed && mult_done) begin
            result <= mult_product;
         end
      end
   end

   assign resp_product = result;
   assign busy         = (state != IDLE);

endmodule
`default_nettype wire
